cpu7_tlb_dmw: RTL and testbench
===============================

Name: cpu7_tlb_dmw

Overview:
- Multi-channel address-translation unit for the cpu7 core top.
- Sits between the cache request side (inst/data tlb_req, tlb_vaddr) and the cache paddr/finish/hit/uncache/exccode inputs.
- Translates through NWIN software-programmable direct-mapped windows plus a direct-address (DA) mode.
- Result latency is a fixed, parametrised LAT cycles. Full per-cycle throughput per channel. Per-channel cancel.

Parameters:
NCH, 2, number of independent translation channels (ch0 = inst, ch1 = data by convention)
NWIN, 2, number of direct-mapped windows (1..4)
GRLEN, 32, virtual address width
PABITS, 32, physical address width (<= GRLEN)
LAT, 1, request-to-finish latency in cycles (1..4)

Ports:
clk  in  1  core clock
resetn  in  1  reset, asynchronous assert, active-low
cfg_wen  in  1  write one window/mode register
cfg_idx  in  3  0..NWIN-1 = window index; 7 = mode register; others ignored
cfg_wdata  in  9  window: {en, vseg[2:0], pseg[2:0], mat[1:0]}; mode: {da, mat[1:0]} in bits[2:0]
tlb_req  in  NCH  per-channel translation request (single-cycle pulse per request)
tlb_vaddr  in  NCH*GRLEN  per-channel virtual address, valid with tlb_req
tlb_cancel  in  NCH  kill all in-flight requests of that channel
tlb_finish  out  NCH  result valid, exactly LAT cycles after accepted tlb_req
tlb_hit  out  NCH  translation succeeded (valid with finish)
tlb_paddr  out  NCH*PABITS  physical address (valid with finish)
tlb_uncache  out  NCH  1 when mat==0 (strongly-ordered uncached)
tlb_exccode  out  NCH*6  0 on hit, 6'h3F (refill) on miss

Behaviour:
- Reset values:
  - all tlb_* outputs 0;
  - all windows en=0, vseg/pseg/mat=0;
  - mode da=1, mat=2'b01 (cached).
  - After reset the unit is therefore identity/cached.
- Interface handshake:
  - Every tlb_req is accepted; there is no ready signal.
  - A channel can hold up to LAT requests in flight (shift pipeline).
- Stage 0 (request cycle), computed combinationally from tlb_vaddr and the current config:
  - DA mode (da=1): paddr = vaddr[PABITS-1:0], hit=1, uncache = (mode.mat==0).
  - Otherwise: window w hits if en[w] && vaddr[GRLEN-1:GRLEN-3]==vseg[w].
    - On a hit: paddr = {pseg[w], vaddr[PABITS-4:0]} when PABITS==GRLEN. When PABITS<GRLEN the window replaces bits [PABITS-1:PABITS-3] instead.
    - hit=1, uncache=(mat[w]==0), exccode=0.
  - Several windows hit: lowest index wins.
  - No hit: hit=0, paddr=0, uncache=0, exccode=6'h3F.
- Stages 1..LAT:
  - The result is registered and shifted with a valid bit.
  - tlb_finish = valid of the last stage.
  - All outputs are registered; there is no combinational path from any input to any output.
- Config write timing:
  - A write in cycle t takes effect for requests in cycle t+1 onward.
  - A tlb_req in cycle t uses the old config.
  - In-flight results are never altered by later config writes (snapshot at stage 0).
- Cancel:
  - tlb_cancel[c] in cycle t clears every valid bit of channel c, including a tlb_req[c] presented in the same cycle.
  - tlb_finish[c] stays 0 for all cancelled requests.
  - A request in cycle t+1 is processed normally.
  - Cancel on an idle channel has no effect.
- Independence: channels share config only. Simultaneous requests on all channels are each served with latency LAT.
- Data path when not finishing: outputs hold their last values; only tlb_finish drops.
- Reset mid-operation: all in-flight requests are discarded and config returns to reset values asynchronously.
- Out-of-range values:
  - cfg_idx >= NWIN and != 7: write ignored.
  - cfg_wdata bits beyond the field widths: ignored.

Decomposition:
- Shared header (next to common.vh): window field offsets, mode field offsets, mode cfg_idx value 7, refill exccode 6'h3F, MAT encodings.
- Sub-module cpu7_tlb_dmw_pipe: per-channel LAT-deep valid/data shift register with cancel. Instantiated NCH times by generate.
- Config registers and stage-0 lookup stay in the top.

Test Plan:
- Post-reset, LAT=1: req ch0 vaddr 0x1C000010 → next cycle finish=1, hit=1, paddr=0x1C000010, uncache=0, exccode=0.
- da=0, window0 {en=1, vseg=3'b101, pseg=3'b000, mat=0}: req ch1 vaddr 0xA0001234 → paddr 0x00001234, uncache=1. vaddr 0x80000000 → hit=0, exccode=0x3F, paddr=0.
- LAT=3: back-to-back reqs ch0 on cycles 0,1,2 (vaddr 0x100, 0x200, 0x300) → finish on cycles 3,4,5 with matching paddrs, in order.
- LAT=3: reqs on cycles 0,1, cancel ch0 on cycle 2 together with a new req → no finish on cycles 3,4,5. A req on cycle 3 finishes on cycle 6.
- Config write window0 pseg 0→3'b001 on cycle t with req on cycle t → old paddr. Req on cycle t+1 → paddr with top bits 001.
- Windows 0 and 1 both matching vseg 3'b101 (pseg 000 and 111): paddr uses pseg 000. Concurrent ch0/ch1 requests are served independently. Reset asserted mid-flight → finish=0 immediately, da=1 afterwards.

Source files
------------

// File: rtl/cpu7_tlb_dmw_pkg.sv
// Shared constants for the cpu7 direct-mapped-window translation unit:
// config field offsets, the mode register index, MAT encodings and the refill code.
package cpu7_tlb_dmw_pkg;

   localparam int WIN_EN_BIT   = 8;
   localparam int WIN_VSEG_LSB = 5;
   localparam int WIN_PSEG_LSB = 2;
   localparam int WIN_MAT_LSB  = 0;

   localparam int MODE_DA_BIT  = 2;
   localparam int MODE_MAT_LSB = 0;

   localparam logic [2:0] CFG_IDX_MODE = 3'd7;
   localparam logic [5:0] EXC_NONE     = 6'h00;
   localparam logic [5:0] EXC_REFILL   = 6'h3F;

   localparam logic [1:0] MAT_SUC = 2'b00;
   localparam logic [1:0] MAT_CC  = 2'b01;

   typedef struct packed {
      logic       en;
      logic [2:0] vseg;
      logic [2:0] pseg;
      logic [1:0] mat;
   } win_t;

   function automatic win_t f_unpack_win(input logic [8:0] d);
      win_t w;
      w.en   = d[WIN_EN_BIT];
      w.vseg = d[WIN_VSEG_LSB +: 3];
      w.pseg = d[WIN_PSEG_LSB +: 3];
      w.mat  = d[WIN_MAT_LSB +: 2];
      return w;
   endfunction

endpackage

// File: rtl/cpu7_tlb_dmw_if.sv
// Config write port plus per-channel translation request/result bundle.
interface cpu7_tlb_dmw_if #(
   parameter int NCH    = 2,
   parameter int GRLEN  = 32,
   parameter int PABITS = 32
) ();
   logic                    cfg_wen;
   logic [2:0]              cfg_idx;
   logic [8:0]              cfg_wdata;
   logic [NCH-1:0]          tlb_req;
   logic [NCH*GRLEN-1:0]    tlb_vaddr;
   logic [NCH-1:0]          tlb_cancel;
   logic [NCH-1:0]          tlb_finish;
   logic [NCH-1:0]          tlb_hit;
   logic [NCH*PABITS-1:0]   tlb_paddr;
   logic [NCH-1:0]          tlb_uncache;
   logic [NCH*6-1:0]        tlb_exccode;

   modport master (
      output cfg_wen, cfg_idx, cfg_wdata, tlb_req, tlb_vaddr, tlb_cancel,
      input  tlb_finish, tlb_hit, tlb_paddr, tlb_uncache, tlb_exccode
   );

   modport slave (
      input  cfg_wen, cfg_idx, cfg_wdata, tlb_req, tlb_vaddr, tlb_cancel,
      output tlb_finish, tlb_hit, tlb_paddr, tlb_uncache, tlb_exccode
   );
endinterface

// File: rtl/cpu7_tlb_dmw_pipe.sv
// One channel's LAT-deep result pipeline: valid chain with flush-on-cancel,
// data chain that only advances behind a live request so idle outputs hold.
module cpu7_tlb_dmw_pipe #(
   parameter int LAT = 1,
   parameter int DW  = 40
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          i_valid,
   input  logic          i_cancel,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   output logic [DW-1:0] o_data
);

   logic [LAT-1:0]         r_vld;
   logic [LAT-1:0][DW-1:0] r_data;

   // Valid chain; cancel also kills the request arriving this cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_vld <= '0;
      end else if (i_cancel) begin
         r_vld <= '0;
      end else begin
         r_vld[0] <= i_valid;
         for (int s = 1; s < LAT; s++) begin
            r_vld[s] <= r_vld[s-1];
         end
      end
   end

   // Data chain, moves only with a surviving valid
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_data <= '0;
      end else begin
         if (i_valid && !i_cancel) begin
            r_data[0] <= i_data;
         end
         for (int s = 1; s < LAT; s++) begin
            if (r_vld[s-1] && !i_cancel) begin
               r_data[s] <= r_data[s-1];
            end
         end
      end
   end

   assign o_valid = r_vld[LAT-1];
   assign o_data  = r_data[LAT-1];

endmodule

// File: rtl/cpu7_tlb_dmw.sv
// Direct-mapped-window address translation for NCH channels: config registers,
// stage-0 window lookup per channel, and a registered LAT-cycle result pipeline.
module cpu7_tlb_dmw
   import cpu7_tlb_dmw_pkg::*;
#(
   parameter int NCH    = 2,
   parameter int NWIN   = 2,
   parameter int GRLEN  = 32,
   parameter int PABITS = 32,
   parameter int LAT    = 1
) (
   input  logic           clk,
   input  logic           resetn,
   cpu7_tlb_dmw_if.slave  bus
);

   // Result word: {hit, uncache, exccode[5:0], paddr}
   localparam int DW = PABITS + 8;

   win_t [NWIN-1:0] r_win;
   logic            r_da;
   logic [1:0]      r_mode_mat;

   // Config registers; unknown indices fall through both branches untouched
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_win      <= '0;
         r_da       <= 1'b1;
         r_mode_mat <= MAT_CC;
      end else if (bus.cfg_wen) begin
         if (bus.cfg_idx == CFG_IDX_MODE) begin
            r_da       <= bus.cfg_wdata[MODE_DA_BIT];
            r_mode_mat <= bus.cfg_wdata[MODE_MAT_LSB +: 2];
         end else begin
            for (int w = 0; w < NWIN; w++) begin
               if (bus.cfg_idx == 3'(w)) begin
                  r_win[w] <= f_unpack_win(bus.cfg_wdata);
               end
            end
         end
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [GRLEN-1:0]  w_va;
      logic [NWIN-1:0]   w_match;
      logic              w_any;
      logic [2:0]        w_pseg;
      logic [1:0]        w_mat;
      logic [PABITS-1:0] w_pa;
      logic              w_hit;
      logic              w_unc;
      logic [5:0]        w_exc;
      logic [DW-1:0]     w_res;
      logic              w_vld;
      logic [DW-1:0]     w_q;

      assign w_va = bus.tlb_vaddr[c*GRLEN +: GRLEN];

      // Stage-0 lookup; scanning from the top down leaves the lowest matching window selected
      always_comb begin
         w_match = '0;
         w_any   = 1'b0;
         w_pseg  = 3'b000;
         w_mat   = 2'b00;
         w_pa    = '0;
         w_hit   = 1'b0;
         w_unc   = 1'b0;
         w_exc   = EXC_REFILL;
         for (int w = NWIN - 1; w >= 0; w--) begin
            w_match[w] = r_win[w].en && (w_va[GRLEN-1 -: 3] == r_win[w].vseg);
            w_pseg     = w_match[w] ? r_win[w].pseg : w_pseg;
            w_mat      = w_match[w] ? r_win[w].mat  : w_mat;
            w_any      = w_any | w_match[w];
         end
         if (r_da) begin
            w_pa  = w_va[PABITS-1:0];
            w_hit = 1'b1;
            w_unc = (r_mode_mat == MAT_SUC);
            w_exc = EXC_NONE;
         end else if (w_any) begin
            w_pa              = w_va[PABITS-1:0];
            w_pa[PABITS-1 -: 3] = w_pseg;
            w_hit             = 1'b1;
            w_unc             = (w_mat == MAT_SUC);
            w_exc             = EXC_NONE;
         end else begin
            w_pa  = '0;
            w_hit = 1'b0;
            w_unc = 1'b0;
            w_exc = EXC_REFILL;
         end
      end

      assign w_res = {w_hit, w_unc, w_exc, w_pa};

      cpu7_tlb_dmw_pipe #(
         .LAT (LAT),
         .DW  (DW)
      ) u_pipe (
         .clk      (clk),
         .resetn   (resetn),
         .i_valid  (bus.tlb_req[c]),
         .i_cancel (bus.tlb_cancel[c]),
         .i_data   (w_res),
         .o_valid  (w_vld),
         .o_data   (w_q)
      );

      assign bus.tlb_finish[c]                  = w_vld;
      assign bus.tlb_hit[c]                     = w_q[DW-1];
      assign bus.tlb_uncache[c]                 = w_q[DW-2];
      assign bus.tlb_exccode[c*6 +: 6]          = w_q[PABITS +: 6];
      assign bus.tlb_paddr[c*PABITS +: PABITS]  = w_q[PABITS-1:0];
   end

endmodule

// File: tb/tb_cpu7_tlb_dmw.sv
// Directed bench: one LAT=1 and one LAT=3 instance driven with hand-computed vectors.
module tb_cpu7_tlb_dmw;

   logic clk = 1'b0;
   logic resetn;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   cpu7_tlb_dmw_if #(.NCH(2), .GRLEN(32), .PABITS(32)) bus1 ();
   cpu7_tlb_dmw_if #(.NCH(2), .GRLEN(32), .PABITS(32)) bus3 ();

   cpu7_tlb_dmw #(.NCH(2), .NWIN(2), .GRLEN(32), .PABITS(32), .LAT(1)) u_dut1 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus1)
   );

   cpu7_tlb_dmw #(.NCH(2), .NWIN(2), .GRLEN(32), .PABITS(32), .LAT(3)) u_dut3 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus3)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus1.cfg_wen = 1'b0; bus1.cfg_idx = 3'd0; bus1.cfg_wdata = 9'h000;
      bus1.tlb_req = 2'b00; bus1.tlb_vaddr = 64'h0; bus1.tlb_cancel = 2'b00;
      bus3.cfg_wen = 1'b0; bus3.cfg_idx = 3'd0; bus3.cfg_wdata = 9'h000;
      bus3.tlb_req = 2'b00; bus3.tlb_vaddr = 64'h0; bus3.tlb_cancel = 2'b00;
   endtask

   task automatic cfg1(input logic [2:0] idx, input logic [8:0] data);
      bus1.cfg_wen = 1'b1; bus1.cfg_idx = idx; bus1.cfg_wdata = data;
      tick();
      bus1.cfg_wen = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      idle();
      tick();
      tick();
      check("rst_fin1",  64'(bus1.tlb_finish),  64'h0);
      check("rst_hit1",  64'(bus1.tlb_hit),     64'h0);
      check("rst_pa1",   bus1.tlb_paddr,        64'h0);
      check("rst_exc1",  64'(bus1.tlb_exccode), 64'h0);
      check("rst_fin3",  64'(bus3.tlb_finish),  64'h0);
      resetn = 1'b1;
      tick();

      // Identity/cached after reset
      bus1.tlb_req = 2'b01; bus1.tlb_vaddr = {32'h0, 32'h1C000010};
      tick();
      bus1.tlb_req = 2'b00;
      check("da_fin",  64'(bus1.tlb_finish),       64'h1);
      check("da_hit",  64'(bus1.tlb_hit[0]),       64'h1);
      check("da_pa",   64'(bus1.tlb_paddr[31:0]),  64'h1C000010);
      check("da_unc",  64'(bus1.tlb_uncache[0]),   64'h0);
      check("da_exc",  64'(bus1.tlb_exccode[5:0]), 64'h0);
      tick();
      check("idle_fin",  64'(bus1.tlb_finish),      64'h0);
      check("idle_hold", 64'(bus1.tlb_paddr[31:0]), 64'h1C000010);

      // Window mode: win0 = {en, vseg 101, pseg 000, mat SUC}
      cfg1(3'd7, 9'h001);
      cfg1(3'd0, 9'h1A0);
      bus1.tlb_req = 2'b10; bus1.tlb_vaddr = {32'hA0001234, 32'h0};
      tick();
      check("w0_fin", 64'(bus1.tlb_finish),        64'h2);
      check("w0_hit", 64'(bus1.tlb_hit[1]),        64'h1);
      check("w0_pa",  64'(bus1.tlb_paddr[63:32]),  64'h00001234);
      check("w0_unc", 64'(bus1.tlb_uncache[1]),    64'h1);
      check("w0_exc", 64'(bus1.tlb_exccode[11:6]), 64'h0);
      bus1.tlb_vaddr = {32'h80000000, 32'h0};
      tick();
      bus1.tlb_req = 2'b00;
      check("miss_fin", 64'(bus1.tlb_finish),        64'h2);
      check("miss_hit", 64'(bus1.tlb_hit[1]),        64'h0);
      check("miss_exc", 64'(bus1.tlb_exccode[11:6]), 64'h3F);
      check("miss_pa",  64'(bus1.tlb_paddr[63:32]),  64'h0);
      check("miss_unc", 64'(bus1.tlb_uncache[1]),    64'h0);

      // Config write in the request cycle is not yet visible
      bus1.cfg_wen = 1'b1; bus1.cfg_idx = 3'd0; bus1.cfg_wdata = 9'h1A4;
      bus1.tlb_req = 2'b01; bus1.tlb_vaddr = {32'h0, 32'hA0000010};
      tick();
      bus1.cfg_wen = 1'b0;
      check("cfg_old", 64'(bus1.tlb_paddr[31:0]), 64'h00000010);
      tick();
      bus1.tlb_req = 2'b00;
      check("cfg_new", 64'(bus1.tlb_paddr[31:0]), 64'h20000010);

      // Two matching windows: lowest index wins; channels independent
      cfg1(3'd1, 9'h1BD);
      cfg1(3'd0, 9'h1A0);
      bus1.tlb_req = 2'b11; bus1.tlb_vaddr = {32'h40000040, 32'hA0000020};
      tick();
      bus1.tlb_req = 2'b00;
      check("pri_fin",  64'(bus1.tlb_finish),        64'h3);
      check("pri_pa",   64'(bus1.tlb_paddr[31:0]),   64'h00000020);
      check("pri_unc",  64'(bus1.tlb_uncache[0]),    64'h1);
      check("ch1_miss", 64'(bus1.tlb_exccode[11:6]), 64'h3F);
      check("ch1_hit",  64'(bus1.tlb_hit[1]),        64'h0);

      // Window 0 off, window 2 does not exist: win1 still used
      cfg1(3'd0, 9'h0A0);
      cfg1(3'd2, 9'h1A0);
      bus1.tlb_req = 2'b01; bus1.tlb_vaddr = {32'h0, 32'hA0000044};
      tick();
      bus1.tlb_req = 2'b00;
      check("w1_pa",  64'(bus1.tlb_paddr[31:0]), 64'hE0000044);
      check("w1_unc", 64'(bus1.tlb_uncache[0]),  64'h0);

      // LAT=3 back-to-back
      bus3.tlb_req = 2'b01; bus3.tlb_vaddr = {32'h0, 32'h100};
      tick();
      bus3.tlb_vaddr = {32'h0, 32'h200};
      tick();
      bus3.tlb_vaddr = {32'h0, 32'h300};
      check("b2b_early", 64'(bus3.tlb_finish), 64'h0);
      tick();
      bus3.tlb_req = 2'b00;
      check("b2b_f0", 64'(bus3.tlb_finish),      64'h1);
      check("b2b_p0", 64'(bus3.tlb_paddr[31:0]), 64'h100);
      tick();
      check("b2b_f1", 64'(bus3.tlb_finish),      64'h1);
      check("b2b_p1", 64'(bus3.tlb_paddr[31:0]), 64'h200);
      tick();
      check("b2b_f2", 64'(bus3.tlb_finish),      64'h1);
      check("b2b_p2", 64'(bus3.tlb_paddr[31:0]), 64'h300);
      tick();
      check("b2b_end", 64'(bus3.tlb_finish), 64'h0);

      // LAT=3 cancel on ch0 while ch1 keeps running
      bus3.tlb_req = 2'b01; bus3.tlb_vaddr = {32'h0, 32'h400};
      tick();
      bus3.tlb_req = 2'b11; bus3.tlb_vaddr = {32'h800, 32'h500};
      tick();
      bus3.tlb_req = 2'b01; bus3.tlb_vaddr = {32'h0, 32'h600}; bus3.tlb_cancel = 2'b01;
      tick();
      bus3.tlb_cancel = 2'b00;
      check("can_c3", 64'(bus3.tlb_finish), 64'h0);
      bus3.tlb_req = 2'b01; bus3.tlb_vaddr = {32'h0, 32'h700};
      tick();
      bus3.tlb_req = 2'b00;
      check("can_c4",  64'(bus3.tlb_finish),       64'h2);
      check("can_ch1", 64'(bus3.tlb_paddr[63:32]), 64'h800);
      tick();
      check("can_c5", 64'(bus3.tlb_finish), 64'h0);
      tick();
      check("can_c6",  64'(bus3.tlb_finish),      64'h1);
      check("can_pa6", 64'(bus3.tlb_paddr[31:0]), 64'h700);
      tick();

      // Reset mid-flight
      bus3.tlb_req = 2'b01; bus3.tlb_vaddr = {32'h0, 32'h900};
      tick();
      bus3.tlb_vaddr = {32'h0, 32'hA00};
      tick();
      bus3.tlb_req = 2'b00;
      tick();
      check("pre_rst_fin", 64'(bus3.tlb_finish), 64'h1);
      resetn = 1'b0;
      #1;
      check("rst_async_fin", 64'(bus3.tlb_finish),      64'h0);
      check("rst_async_pa",  64'(bus3.tlb_paddr[31:0]), 64'h0);
      tick();
      resetn = 1'b1;
      tick();
      check("rst_drop1", 64'(bus3.tlb_finish), 64'h0);
      tick();
      check("rst_drop2", 64'(bus3.tlb_finish), 64'h0);

      // Mode back to DA after reset
      bus1.tlb_req = 2'b01; bus1.tlb_vaddr = {32'h0, 32'hA2345678};
      tick();
      bus1.tlb_req = 2'b00;
      check("post_rst_hit", 64'(bus1.tlb_hit[0]),      64'h1);
      check("post_rst_pa",  64'(bus1.tlb_paddr[31:0]), 64'hA2345678);
      check("post_rst_unc", 64'(bus1.tlb_uncache[0]),  64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
